// File: rtl/main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control and its ula_control
// consumer: FSM states, opcodes, ula_operation codes and datapath selects.
package main_control_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ULA_OP_W = 3;
  localparam int unsigned SEL_W    = 2;

  // Unused encodings 12..15 fall back to FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  // ula_operation codes understood by ula_control.
  localparam logic [ULA_OP_W-1:0] ULA_ADD   = 3'b000;
  localparam logic [ULA_OP_W-1:0] ULA_SUB   = 3'b001;
  localparam logic [ULA_OP_W-1:0] ULA_FUNCT = 3'b010;
  localparam logic [ULA_OP_W-1:0] ULA_SLT   = 3'b011;
  localparam logic [ULA_OP_W-1:0] ULA_AND   = 3'b100;
  localparam logic [ULA_OP_W-1:0] ULA_OR    = 3'b101;
  localparam logic [ULA_OP_W-1:0] ULA_XOR   = 3'b110;
  localparam logic [ULA_OP_W-1:0] ULA_LUI   = 3'b111;

  localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ULA    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ULAOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/i_type_ula_decode.sv
// Combinational opcode -> ula_operation map for I-type ALU instructions.
// Ports: opcode (in, 6) ; ula_operation (out, 3), ADD for non I-type opcodes.
module i_type_ula_decode
  import main_control_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ULA_OP_W-1:0] ula_operation
);

  always_comb begin
    ula_operation = ULA_ADD;
    case (opcode)
      OP_ADDI: ula_operation = ULA_ADD;
      OP_SLTI: ula_operation = ULA_SLT;
      OP_ANDI: ula_operation = ULA_AND;
      OP_ORI:  ula_operation = ULA_OR;
      OP_XORI: ula_operation = ULA_XOR;
      OP_LUI:  ula_operation = ULA_LUI;
      default: ula_operation = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/main_control_multicycle.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/memory/
// write-back and drives datapath selects, write enables and ula_operation.
// Ports: clock, reset (sync, active-high); opcode, zero in;
//   pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, ula_src_a, ula_src_b[1:0], pc_source[1:0], ula_operation[2:0],
//   illegal, state_out[3:0], instr_count[COUNT_WIDTH-1:0] out.
module main_control_multicycle
  import main_control_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [OPCODE_W-1:0]    opcode,
  input  logic                   zero,
  output logic                   pc_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   ula_src_a,
  output logic [SEL_W-1:0]       ula_src_b,
  output logic [SEL_W-1:0]       pc_source,
  output logic [ULA_OP_W-1:0]    ula_operation,
  output logic                   illegal,
  output logic [STATE_W-1:0]     state_out,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  state_t               state;
  state_t               next_state;
  state_t               cur;
  logic                 retire;
  logic [ULA_OP_W-1:0]  i_ula_op;

  i_type_ula_decode u_i_dec (
    .opcode        (opcode),
    .ula_operation (i_ula_op)
  );

  // State register and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  // Next state and Moore outputs; reset presents FETCH with writes masked.
  always_comb begin
    cur           = reset ? S_FETCH : state;
    next_state    = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    ula_src_a     = 1'b0;
    ula_src_b     = SRCB_B;
    pc_source     = PCSRC_ULA;
    ula_operation = ULA_ADD;
    illegal       = 1'b0;

    case (cur)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        ula_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed here into ULA out.
        ula_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:       next_state = S_R_EXEC;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:           next_state = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                          next_state = S_I_EXEC;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ula_src_a = 1'b1;
        ula_src_b = SRCB_IMM;
        if (opcode == OP_LW)      next_state = S_MEM_READ;
        else if (opcode == OP_SW) next_state = S_MEM_WRITE;
        else                      next_state = S_FETCH;
      end
      S_MEM_READ: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = 1'b1;
      end
      S_R_EXEC: begin
        ula_src_a     = 1'b1;
        ula_operation = ULA_FUNCT;
        next_state    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      S_I_EXEC: begin
        ula_src_a     = 1'b1;
        ula_src_b     = SRCB_IMM;
        ula_operation = i_ula_op;
        next_state    = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        ula_src_a     = 1'b1;
        ula_operation = ULA_SUB;
        pc_source     = PCSRC_ULAOUT;
        pc_write      = (opcode == OP_BNE) ? ~zero : zero;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;
      next_state = S_FETCH;
    end
  end

  assign state_out = cur;

endmodule
